// File: rtl/i2c_bit_ctrl_pkg.sv
// Shared definitions for the I2C bit sequencer: command and phase encodings,
// plus the per-phase open-drain drive table.
package i2c_defs;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_Q0   = 3'd2,
    ST_Q1   = 3'd3,
    ST_Q2   = 3'd4,
    ST_Q3   = 3'd5
  } state_t;

  // Returns {scl_oe, sda_oe} for a quarter phase; 1 = pull line low.
  function automatic logic [1:0] phase_oe(input cmd_t cmd, input state_t ph, input logic tx);
    logic [1:0] oe;
    oe = 2'b00;
    case (cmd)
      CMD_START: oe = (ph == ST_Q3) ? 2'b11 : (ph == ST_Q2) ? 2'b01 : 2'b00;
      CMD_STOP:  oe = (ph == ST_Q0) ? 2'b11 : (ph == ST_Q3) ? 2'b00 : 2'b01;
      CMD_WRITE: oe = {(ph == ST_Q0) || (ph == ST_Q3), ~tx};
      CMD_READ:  oe = {(ph == ST_Q0) || (ph == ST_Q3), 1'b0};
      default:   oe = 2'b00;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_timer.sv
// Quarter-phase timer: after Start, pulses once every Ticks+1 cycles until Stop.
module i2c_bit_timer #(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Stop,
  input  logic [SIZE-1:0] Ticks,
  output logic            Pulse
);

  logic            run;
  logic [SIZE-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (Stop) begin
      run <= 1'b0;
    end else if (Start) begin
      run <= 1'b1;
      cnt <= Ticks;
    end else if (run) begin
      cnt <= (cnt == '0) ? Ticks : cnt - SIZE'(1);
    end
  end

  assign Pulse = run && (cnt == '0);

endmodule

// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level sequencer: one START/STOP/WRITE/READ per handshake, four
// timed quarter phases, with SCL stretching and arbitration-loss detection.
module i2c_bit_ctrl
  import i2c_defs::*;
#(
  parameter int SIZE = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Enable,
  input  logic [SIZE-1:0] Divider,
  input  logic [1:0]      Cmd,
  input  logic            Cmd_valid,
  output logic            Cmd_ready,
  input  logic            Tx_bit,
  output logic            Rx_bit,
  output logic            Done,
  output logic            Arb_lost,
  output logic            Busy,
  input  logic            Scl_in,
  input  logic            Sda_in,
  output logic            Scl_oe,
  output logic            Sda_oe
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;
  state_t     state, nxt_ph;
  cmd_t       cmd_q;
  logic       tx_q, stretch, tmr_start, tmr_stop, pulse, arb_hit;
  logic [1:0] nxt_oe, q0_oe;

  // Idle bus is pulled up, so synchronisers reset high.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], Scl_in};
      sda_sync <= {sda_sync[0], Sda_in};
    end
  end
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  i2c_bit_timer #(.SIZE(SIZE)) u_timer (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (tmr_start),
    .Stop  (tmr_stop),
    .Ticks (Divider),
    .Pulse (pulse)
  );

  assign nxt_ph    = state_t'(state + 3'd1);
  assign nxt_oe    = phase_oe(cmd_q, nxt_ph, tx_q);
  assign q0_oe     = phase_oe(cmd_q, ST_Q0, tx_q);
  assign arb_hit   = !sda_s &&
                     ((cmd_q == CMD_WRITE && tx_q && (state == ST_Q1 || state == ST_Q2)) ||
                      (cmd_q == CMD_START && state == ST_Q0));
  assign Busy      = (state != ST_IDLE);
  assign Cmd_ready = Enable && (state == ST_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_START;
      tx_q      <= 1'b0;
      stretch   <= 1'b0;
      tmr_start <= 1'b0;
      tmr_stop  <= 1'b1;
      Scl_oe    <= 1'b0;
      Sda_oe    <= 1'b0;
      Done      <= 1'b0;
      Arb_lost  <= 1'b0;
      Rx_bit    <= 1'b0;
    end else begin
      Done      <= 1'b0;
      Arb_lost  <= 1'b0;
      tmr_start <= 1'b0;
      if (!Enable) begin
        state    <= ST_IDLE;
        stretch  <= 1'b0;
        tmr_stop <= 1'b1;
        Scl_oe   <= 1'b0;
        Sda_oe   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (Cmd_valid) begin
            cmd_q <= cmd_t'(Cmd);
            tx_q  <= Tx_bit;
            state <= ST_ARM;
          end
          // Any pulse seen while Start is in flight belongs to the previous run.
          ST_ARM: begin
            tmr_stop  <= 1'b0;
            tmr_start <= 1'b1;
            state     <= ST_Q0;
            {Scl_oe, Sda_oe} <= q0_oe;
          end
          ST_Q0, ST_Q1, ST_Q2, ST_Q3: begin
            if (stretch) begin
              if (scl_s) begin
                stretch   <= 1'b0;
                tmr_stop  <= 1'b0;
                tmr_start <= 1'b1;
              end
            end else if (pulse && !tmr_start) begin
              if (!Scl_oe && !scl_s) begin
                stretch  <= 1'b1;
                tmr_stop <= 1'b1;
              end else if (arb_hit) begin
                Arb_lost <= 1'b1;
                Scl_oe   <= 1'b0;
                Sda_oe   <= 1'b0;
                tmr_stop <= 1'b1;
                state    <= ST_IDLE;
              end else if (state == ST_Q3) begin
                // Lines keep their Q3 levels until the next command.
                Done     <= 1'b1;
                tmr_stop <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                if (cmd_q == CMD_READ && state == ST_Q1) Rx_bit <= sda_s;
                state <= nxt_ph;
                {Scl_oe, Sda_oe} <= nxt_oe;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl: open-drain bus model with a slave that can
// stretch SCL or pull SDA low, Divider=3 so a clean command takes 18 cycles.
module tb_i2c_bit_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n, Enable, Cmd_valid, Tx_bit;
  logic [7:0] Divider;
  logic [1:0] Cmd;
  logic       Cmd_ready, Rx_bit, Done, Arb_lost, Busy;
  logic       Scl_in, Sda_in, Scl_oe, Sda_oe;
  logic       scl_hold, sda_low;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  assign Scl_in = !Scl_oe && !scl_hold;
  assign Sda_in = !Sda_oe && !sda_low;

  i2c_bit_ctrl #(.SIZE(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Enable    (Enable),
    .Divider   (Divider),
    .Cmd       (Cmd),
    .Cmd_valid (Cmd_valid),
    .Cmd_ready (Cmd_ready),
    .Tx_bit    (Tx_bit),
    .Rx_bit    (Rx_bit),
    .Done      (Done),
    .Arb_lost  (Arb_lost),
    .Busy      (Busy),
    .Scl_in    (Scl_in),
    .Sda_in    (Sda_in),
    .Scl_oe    (Scl_oe),
    .Sda_oe    (Sda_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [1:0] c, input logic t);
    Cmd = c; Tx_bit = t; Cmd_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Cmd_valid = 1'b0;
  endtask

  // Runs one command; n counts posedges after the accept edge. trace holds
  // {Scl_oe,Sda_oe} at n=4,8,12,16 (mid Q0..Q3 when unstretched).
  task automatic run_cmd(input logic [1:0] c, input logic t, input int hold_at, input int hold_len,
                         input int sda_from, output int lat, output logic [7:0] trace,
                         output logic got_done, output logic got_arb);
    lat = -1; trace = '0; got_done = 1'b0; got_arb = 1'b0;
    scl_hold = 1'b0;
    if (sda_from == 0) sda_low = 1'b1;
    issue(c, t);
    for (int n = 1; n <= 80; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      scl_hold = (hold_len > 0) && (n >= hold_at) && (n < hold_at + hold_len);
      if (sda_from >= 0 && n >= sda_from) sda_low = 1'b1;
      case (n)
        4:  trace[7:6] = {Scl_oe, Sda_oe};
        8:  trace[5:4] = {Scl_oe, Sda_oe};
        12: trace[3:2] = {Scl_oe, Sda_oe};
        16: trace[1:0] = {Scl_oe, Sda_oe};
        default: ;
      endcase
      if (Done || Arb_lost) begin
        got_done = Done; got_arb = Arb_lost; lat = n;
        break;
      end
    end
    scl_hold = 1'b0;
  endtask

  int         lat;
  logic [7:0] tr;
  logic       gd, ga, seen_done;

  initial begin
    Rst_n = 1'b0; Enable = 1'b1; Divider = 8'd3; Cmd = 2'b00; Cmd_valid = 1'b0; Tx_bit = 1'b0;
    scl_hold = 1'b0; sda_low = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_scl_oe", Scl_oe, 0);
    check("rst_sda_oe", Sda_oe, 0);
    check("rst_done", Done, 0);
    check("rst_arb", Arb_lost, 0);
    check("rst_busy", Busy, 0);
    check("rst_rx", Rx_bit, 0);
    check("rst_ready", Cmd_ready, 1);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // START then STOP back-to-back
    run_cmd(2'b00, 1'b0, 0, 0, -1, lat, tr, gd, ga);
    check("start_lat", lat, 18);
    check("start_done", gd, 1);
    check("start_trace", tr, 8'h07);
    check("start_hold_q3", {Scl_oe, Sda_oe}, 2'b11);
    check("start_ready", Cmd_ready, 1);
    run_cmd(2'b01, 1'b0, 0, 0, -1, lat, tr, gd, ga);
    check("stop_lat", lat, 18);
    check("stop_trace", tr, 8'hD4);
    check("stop_end_oe", {Scl_oe, Sda_oe}, 2'b00);

    // WRITE 1 then WRITE 0
    run_cmd(2'b10, 1'b1, 0, 0, -1, lat, tr, gd, ga);
    check("wr1_lat", lat, 18);
    check("wr1_trace", tr, 8'h82);
    run_cmd(2'b10, 1'b0, 0, 0, -1, lat, tr, gd, ga);
    check("wr0_lat", lat, 18);
    check("wr0_trace", tr, 8'hD7);

    // READ with SDA high, then with slave holding SDA low
    run_cmd(2'b11, 1'b0, 0, 0, -1, lat, tr, gd, ga);
    check("rd1_lat", lat, 18);
    check("rd1_trace", tr, 8'h82);
    check("rd1_rx", Rx_bit, 1);
    run_cmd(2'b11, 1'b0, 0, 0, 0, lat, tr, gd, ga);
    check("rd0_done", gd, 1);
    check("rd0_rx", Rx_bit, 0);
    sda_low = 1'b0;

    // Slave stretches SCL for 20 cycles starting at Q0 entry; Q1 is held
    run_cmd(2'b10, 1'b1, 2, 20, -1, lat, tr, gd, ga);
    check("stretch_lat", lat, 38);
    check("stretch_done", gd, 1);
    check("stretch_trace", tr, 8'h80);

    // WRITE 1 loses arbitration in Q1
    run_cmd(2'b10, 1'b1, 0, 0, 6, lat, tr, gd, ga);
    check("arb_wr_lat", lat, 10);
    check("arb_wr_flag", ga, 1);
    check("arb_wr_nodone", gd, 0);
    check("arb_wr_oe", {Scl_oe, Sda_oe}, 2'b00);
    @(negedge Clk);
    check("arb_wr_pulse", Arb_lost, 0);
    sda_low = 1'b0;
    repeat (2) @(negedge Clk);

    // START onto a bus whose SDA is already low
    run_cmd(2'b00, 1'b0, 0, 0, 0, lat, tr, gd, ga);
    check("arb_st_lat", lat, 6);
    check("arb_st_flag", ga, 1);
    check("arb_st_nodone", gd, 0);
    sda_low = 1'b0;
    repeat (2) @(negedge Clk);

    // Enable dropped during READ Q2
    issue(2'b11, 1'b0);
    repeat (11) @(negedge Clk);
    check("en_busy_before", Busy, 1);
    Enable = 1'b0;
    @(negedge Clk);
    check("en_busy", Busy, 0);
    check("en_oe", {Scl_oe, Sda_oe}, 2'b00);
    check("en_ready", Cmd_ready, 0);
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (Done || Arb_lost) seen_done = 1'b1;
    end
    check("en_no_done", seen_done, 0);
    Enable = 1'b1;
    @(negedge Clk);

    // Reset asserted mid-WRITE 0 (Q1, SDA driven low)
    issue(2'b10, 1'b0);
    repeat (8) @(negedge Clk);
    check("rstm_sda_before", Sda_oe, 1);
    check("rstm_ready_busy", Cmd_ready, 0);
    Rst_n = 1'b0;
    #1;
    check("rstm_oe", {Scl_oe, Sda_oe}, 2'b00);
    check("rstm_busy", Busy, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
